// File: rtl/logic_tree_exerciser.sv
// Exhaustive 64-vector sweep of a 6-input logic tree; y_in is checked against the golden
// function RESP_LAT cycles after each vector. Optional first-failure log: LOGIC_TREE_EXERCISER_ERR_LOG_EN.
module logic_tree_exerciser #(
  parameter int unsigned RESP_LAT = 1
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       start,
  output logic [5:0] vec_out,
  input  logic       y_in,
  output logic       busy,
  output logic       done,
  output logic       pass,
  output logic [6:0] err_cnt
`ifdef LOGIC_TREE_EXERCISER_ERR_LOG_EN
  ,
  output logic       first_err_valid,
  output logic [5:0] first_err_vec
`endif
);

  localparam int unsigned VEC_W = 6;
  localparam int unsigned CNT_W = 7;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_DRIVE = 2'd1,
    S_DRAIN = 2'd2,
    S_DONE  = 2'd3
  } state_t;

  state_t             r_state;
  logic [1:0]         r_drain_cnt;
  logic [VEC_W-1:0]   r_vec;
  logic               r_busy;
  logic               r_done;
  logic               r_pass;
  logic [CNT_W-1:0]   r_err_cnt;

  logic               w_sweep_start;
  logic               w_drive;
  logic               w_cmp_valid;
  logic               w_cmp_exp;
  logic               w_mismatch;

  function automatic logic f_golden(input logic [VEC_W-1:0] v);
    return ((v[5] & v[4]) & (v[3] & v[2])) | (v[1] & v[0]);
  endfunction

  assign w_sweep_start = start && ((r_state == S_IDLE) || (r_state == S_DONE));
  assign w_drive       = (r_state == S_DRIVE);
  assign w_mismatch    = w_cmp_valid && (y_in != w_cmp_exp);

  assign vec_out = r_vec;
  assign busy    = r_busy;
  assign done    = r_done;
  assign pass    = r_pass;
  assign err_cnt = r_err_cnt;

`ifdef LOGIC_TREE_EXERCISER_ERR_LOG_EN
  logic [VEC_W-1:0] w_cmp_vec;
  logic             r_first_err_valid;
  logic [VEC_W-1:0] r_first_err_vec;

  assign first_err_valid = r_first_err_valid;
  assign first_err_vec   = r_first_err_vec;
`endif

  // Align golden value (and vector) with the response latency of the tree under test
  if (RESP_LAT == 0) begin : g_comb_cmp
    assign w_cmp_valid = w_drive;
    assign w_cmp_exp   = f_golden(r_vec);
`ifdef LOGIC_TREE_EXERCISER_ERR_LOG_EN
    assign w_cmp_vec   = r_vec;
`endif
  end else begin : g_pipe_cmp
    localparam int unsigned PV_W = VEC_W * RESP_LAT;
    logic [RESP_LAT-1:0] r_pipe_valid;
    logic [RESP_LAT-1:0] r_pipe_exp;

    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        r_pipe_valid <= '0;
        r_pipe_exp   <= '0;
      end else begin
        r_pipe_valid <= w_sweep_start ? '0 : RESP_LAT'({r_pipe_valid, w_drive});
        r_pipe_exp   <= RESP_LAT'({r_pipe_exp, f_golden(r_vec)});
      end
    end

    assign w_cmp_valid = r_pipe_valid[RESP_LAT-1];
    assign w_cmp_exp   = r_pipe_exp[RESP_LAT-1];

`ifdef LOGIC_TREE_EXERCISER_ERR_LOG_EN
    logic [PV_W-1:0] r_pipe_vec;

    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) r_pipe_vec <= '0;
      else        r_pipe_vec <= PV_W'({r_pipe_vec, r_vec});
    end

    assign w_cmp_vec = r_pipe_vec[PV_W-1 -: VEC_W];
`endif
  end

  // Sweep sequencing, error accounting and registered status outputs
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state     <= S_IDLE;
      r_drain_cnt <= '0;
      r_vec       <= '0;
      r_busy      <= 1'b0;
      r_done      <= 1'b0;
      r_pass      <= 1'b1;
      r_err_cnt   <= '0;
`ifdef LOGIC_TREE_EXERCISER_ERR_LOG_EN
      r_first_err_valid <= 1'b0;
      r_first_err_vec   <= '0;
`endif
    end else begin
      if (w_sweep_start) begin
        r_err_cnt <= '0;
        r_pass    <= 1'b1;
`ifdef LOGIC_TREE_EXERCISER_ERR_LOG_EN
        r_first_err_valid <= 1'b0;
        r_first_err_vec   <= '0;
`endif
      end else if (w_mismatch) begin
        r_err_cnt <= r_err_cnt + CNT_W'(1);
        r_pass    <= 1'b0;
`ifdef LOGIC_TREE_EXERCISER_ERR_LOG_EN
        if (!r_first_err_valid) begin
          r_first_err_valid <= 1'b1;
          r_first_err_vec   <= w_cmp_vec;
        end
`endif
      end

      case (r_state)
        S_IDLE, S_DONE: begin
          if (start) begin
            r_state <= S_DRIVE;
            r_vec   <= '0;
            r_busy  <= 1'b1;
            r_done  <= 1'b0;
          end
        end
        S_DRIVE: begin
          if (r_vec == VEC_W'(63)) begin
            r_vec <= '0;
            if (RESP_LAT == 0) begin
              r_state <= S_DONE;
              r_busy  <= 1'b0;
              r_done  <= 1'b1;
            end else begin
              r_state     <= S_DRAIN;
              r_drain_cnt <= 2'(RESP_LAT - 1);
            end
          end else begin
            r_vec <= r_vec + VEC_W'(1);
          end
        end
        S_DRAIN: begin
          if (r_drain_cnt == 2'd0) begin
            r_state <= S_DONE;
            r_busy  <= 1'b0;
            r_done  <= 1'b1;
          end else begin
            r_drain_cnt <= r_drain_cnt - 2'd1;
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_logic_tree_exerciser.sv
// Bench for logic_tree_exerciser: three instances (RESP_LAT 0, 1, 3) driven by a behavioural
// tree model with optional per-vector response corruption; table-driven sweeps plus reset/restart sequences.
module tb_logic_tree_exerciser;

  logic       clk = 1'b0;
  logic       rst_n;
  logic [2:0] st;
  logic [2:0] yv;
  logic [2:0] bz;
  logic [2:0] dn;
  logic [2:0] ps;
  logic [5:0] vo [3];
  logic [6:0] ec [3];
`ifdef LOGIC_TREE_EXERCISER_ERR_LOG_EN
  logic [2:0] fev;
  logic [5:0] fvec [3];
`endif

  int          n_vec = 0;
  int          n_mis = 0;
  int          ymode [3];
  logic [63:0] yflip [3];
  logic [5:0]  hist  [3][3];

  typedef struct {
    int d;
    int mode;
    bit mid;
    int exp_err;
    int exp_lat;
    int exp_first;
  } row_t;

  row_t tbl [10];

  always #5 clk = ~clk;

  logic_tree_exerciser #(.RESP_LAT(0)) u_dut0 (
    .clk(clk), .rst_n(rst_n), .start(st[0]), .vec_out(vo[0]), .y_in(yv[0]),
    .busy(bz[0]), .done(dn[0]), .pass(ps[0]), .err_cnt(ec[0])
`ifdef LOGIC_TREE_EXERCISER_ERR_LOG_EN
    , .first_err_valid(fev[0]), .first_err_vec(fvec[0])
`endif
  );

  logic_tree_exerciser #(.RESP_LAT(1)) u_dut1 (
    .clk(clk), .rst_n(rst_n), .start(st[1]), .vec_out(vo[1]), .y_in(yv[1]),
    .busy(bz[1]), .done(dn[1]), .pass(ps[1]), .err_cnt(ec[1])
`ifdef LOGIC_TREE_EXERCISER_ERR_LOG_EN
    , .first_err_valid(fev[1]), .first_err_vec(fvec[1])
`endif
  );

  logic_tree_exerciser #(.RESP_LAT(3)) u_dut3 (
    .clk(clk), .rst_n(rst_n), .start(st[2]), .vec_out(vo[2]), .y_in(yv[2]),
    .busy(bz[2]), .done(dn[2]), .pass(ps[2]), .err_cnt(ec[2])
`ifdef LOGIC_TREE_EXERCISER_ERR_LOG_EN
    , .first_err_valid(fev[2]), .first_err_vec(fvec[2])
`endif
  );

  function automatic int lat_of(input int d);
    return (d == 0) ? 0 : ((d == 1) ? 1 : 3);
  endfunction

  function automatic logic ref_exp(input int v);
    logic a, b, c, dd, e, f;
    a  = ((v >> 5) & 1) != 0;
    b  = ((v >> 4) & 1) != 0;
    c  = ((v >> 3) & 1) != 0;
    dd = ((v >> 2) & 1) != 0;
    e  = ((v >> 1) & 1) != 0;
    f  = (v & 1) != 0;
    return ((a & b) & (c & dd)) | (e & f);
  endfunction

  // Mode 0: correct tree xor flip mask (flip=0 is a clean tree), 1: tied 0, 2: tied 1
  function automatic logic tree_resp(input int mode, input logic [63:0] flip, input int v);
    logic [5:0] idx;
    idx = 6'(v);
    if (mode == 1) return 1'b0;
    if (mode == 2) return 1'b1;
    return ref_exp(v) ^ flip[idx];
  endfunction

  always @(posedge clk) begin
    for (int d = 0; d < 3; d++) begin
      hist[d][0] <= vo[d];
      hist[d][1] <= hist[d][0];
      hist[d][2] <= hist[d][1];
    end
  end

  always_comb begin
    for (int d = 0; d < 3; d++) begin
      if (lat_of(d) == 0) yv[d] = tree_resp(ymode[d], yflip[d], int'(vo[d]));
      else                yv[d] = tree_resp(ymode[d], yflip[d], int'(hist[d][lat_of(d) - 1]));
    end
  end

  task automatic chk(input string nm, input int act, input int req);
    n_vec++;
    if (act != req) begin
      n_mis++;
      $display("FAIL %s: got %0d, required %0d (t=%0t)", nm, act, req, $time);
    end
  endtask

  task automatic model(input int mode, input logic [63:0] flip, output int errs, output int first);
    errs  = 0;
    first = -1;
    for (int v = 0; v < 64; v++) begin
      if (tree_resp(mode, flip, v) != ref_exp(v)) begin
        errs++;
        if (first < 0) first = v;
      end
    end
  endtask

  task automatic run_sweep(input int d, input int mode, input logic [63:0] flip, input bit mid,
                           input int exp_err, input int exp_lat, input int exp_first);
    int n, vec_bad, m_err, m_first, e_err, e_first;
    ymode[d] = mode;
    yflip[d] = flip;
    model(mode, flip, m_err, m_first);
    e_err   = (exp_err < 0) ? m_err : exp_err;
    e_first = (exp_err < 0) ? m_first : exp_first;
    @(negedge clk);
    st[d] = 1'b1;
    @(posedge clk);
    #1;
    st[d] = 1'b0;
    chk("start_busy", int'(bz[d]), 1);
    chk("start_done", int'(dn[d]), 0);
    chk("start_vec", int'(vo[d]), 0);
    chk("start_err_clear", int'(ec[d]), 0);
    n = 0;
    vec_bad = 0;
    while (n < 200 && !dn[d]) begin
      if (n < 64 && int'(vo[d]) != n) vec_bad++;
      if (n >= 64 && vo[d] != 6'd0) vec_bad++;
      if (mid && n == 10) st[d] = 1'b1;
      if (mid && n == 11) st[d] = 1'b0;
      @(posedge clk);
      #1;
      n++;
    end
    chk("done_edge", n, exp_lat);
    chk("vec_sequence_errors", vec_bad, 0);
    chk("err_cnt", int'(ec[d]), e_err);
    chk("pass", int'(ps[d]), (e_first < 0) ? 1 : 0);
    chk("busy_after", int'(bz[d]), 0);
    chk("vec_in_done", int'(vo[d]), 0);
`ifdef LOGIC_TREE_EXERCISER_ERR_LOG_EN
    chk("first_err_valid", int'(fev[d]), (e_first >= 0) ? 1 : 0);
    if (e_first >= 0) chk("first_err_vec", int'(fvec[d]), e_first);
`endif
    repeat (3) @(posedge clk);
    #1;
    chk("done_held", int'(dn[d]), 1);
    chk("err_held", int'(ec[d]), e_err);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: time %0t reached, required finish before it", $time);
    $fatal(1, "bench timeout");
  end

  initial begin
    int g;
    logic [63:0] flip;

    tbl[0] = '{d: 1, mode: 0, mid: 1'b0, exp_err: 0,  exp_lat: 65, exp_first: -1};
    tbl[1] = '{d: 1, mode: 1, mid: 1'b0, exp_err: 19, exp_lat: 65, exp_first: 3};
    tbl[2] = '{d: 1, mode: 0, mid: 1'b0, exp_err: 0,  exp_lat: 65, exp_first: -1};
    tbl[3] = '{d: 0, mode: 2, mid: 1'b0, exp_err: 45, exp_lat: 64, exp_first: 0};
    tbl[4] = '{d: 2, mode: 0, mid: 1'b1, exp_err: 0,  exp_lat: 67, exp_first: -1};
    tbl[5] = '{d: 0, mode: 0, mid: 1'b0, exp_err: 0,  exp_lat: 64, exp_first: -1};
    tbl[6] = '{d: 2, mode: 1, mid: 1'b0, exp_err: 19, exp_lat: 67, exp_first: 3};
    tbl[7] = '{d: 0, mode: 3, mid: 1'b0, exp_err: -1, exp_lat: 64, exp_first: -1};
    tbl[8] = '{d: 1, mode: 3, mid: 1'b1, exp_err: -1, exp_lat: 65, exp_first: -1};
    tbl[9] = '{d: 2, mode: 3, mid: 1'b0, exp_err: -1, exp_lat: 67, exp_first: -1};

    rst_n = 1'b0;
    st    = 3'b000;
    for (int d = 0; d < 3; d++) begin
      ymode[d] = 0;
      yflip[d] = '0;
    end

    #12;
    for (int d = 0; d < 3; d++) begin
      chk("rst_vec", int'(vo[d]), 0);
      chk("rst_busy", int'(bz[d]), 0);
      chk("rst_done", int'(dn[d]), 0);
      chk("rst_err", int'(ec[d]), 0);
      chk("rst_pass", int'(ps[d]), 1);
    end
    @(negedge clk);
    rst_n = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    chk("idle_busy", int'(bz[1]), 0);
    chk("idle_vec", int'(vo[1]), 0);

    for (int i = 0; i < 10; i++) begin
      flip = '0;
      if (tbl[i].mode == 3) flip = {$urandom, $urandom} & {$urandom, $urandom};
      run_sweep(tbl[i].d, (tbl[i].mode == 3) ? 0 : tbl[i].mode, flip, tbl[i].mid,
                tbl[i].exp_err, tbl[i].exp_lat, tbl[i].exp_first);
    end

    // Mid-sweep asynchronous reset with a failing tree, then clean restart from vector 0
    ymode[1] = 1;
    yflip[1] = '0;
    @(negedge clk);
    st[1] = 1'b1;
    @(posedge clk);
    #1;
    st[1] = 1'b0;
    g = 0;
    while (vo[1] != 6'd20 && g < 100) begin
      @(posedge clk);
      #1;
      g++;
    end
    chk("reach_vec20", int'(vo[1]), 20);
    chk("err_at_vec20", int'(ec[1]), 4);
    #2;
    rst_n = 1'b0;
    #1;
    chk("async_rst_vec", int'(vo[1]), 0);
    chk("async_rst_busy", int'(bz[1]), 0);
    chk("async_rst_done", int'(dn[1]), 0);
    chk("async_rst_err", int'(ec[1]), 0);
    chk("async_rst_pass", int'(ps[1]), 1);
`ifdef LOGIC_TREE_EXERCISER_ERR_LOG_EN
    chk("async_rst_first_valid", int'(fev[1]), 0);
`endif
    @(negedge clk);
    rst_n = 1'b1;
    run_sweep(1, 0, '0, 1'b0, 0, 65, -1);

    // Back-to-back: failing sweep, then immediate restart from DONE
    run_sweep(0, 1, '0, 1'b0, 19, 64, 3);
    run_sweep(0, 0, '0, 1'b0, 0, 64, -1);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_mis);
    $finish;
  end

endmodule

// File: doc/logic_tree_exerciser.md
LOGIC_TREE_EXERCISER -- requirements
Module: logic_tree_exerciser

Interface
REQ-001 SHALL have parameter: RESP_LAT, default 1, cycles from vec_out change to matching y_in sample (legal 0..3).
REQ-002 SHALL have one clock and asynchronous active-low reset, ports exactly as follows:
REQ-003 clk  input  1  rising-edge clock.
REQ-004 rst_n  input  1  asynchronous active-low reset.
REQ-005 start  input  1  begin sweep; sampled high only in IDLE or DONE.
REQ-006 vec_out  output  6  stimulus to tree under test, {a,b,c,d,e,f}, bit5 = a.
REQ-007 y_in  input  1  tree-under-test response.
REQ-008 busy  output  1  high in DRIVE and DRAIN.
REQ-009 done  output  1  high in DONE, held until next start.
REQ-010 pass  output  1  err_cnt == 0, meaningful only while done = 1.
REQ-011 err_cnt  output  7  mismatch count for current or last sweep (0..64).

Function
REQ-012 SHALL implement FSM IDLE, DRIVE, DRAIN, DONE; reset state IDLE.
REQ-013 IDLE/DONE + start = 1 at edge k -> DRIVE after edge k; err_cnt cleared to 0 at edge k; vec_out = 0 after edge k.
REQ-014 DRIVE: vec_out increments by 1 every edge, 0..63, with no gaps or repeats.
REQ-015 At edge where vec_out = 63: RESP_LAT = 0 -> DONE; otherwise -> DRAIN.
REQ-016 DRAIN SHALL last exactly RESP_LAT cycles, then -> DONE.
REQ-017 vec_out SHALL be 0 in IDLE, DRAIN and DONE.
REQ-018 Golden value per vector: exp = ((a & b) & (c & d)) | (e & f).
REQ-019 exp and a valid flag SHALL travel a RESP_LAT-deep shift pipeline; RESP_LAT = 0 compares combinationally against the current vec_out.
REQ-020 Vector v (driven after edge k+v) SHALL be compared with y_in at edge k+1+v+RESP_LAT; last compare at edge k+64+RESP_LAT, same edge as entry to DONE.
REQ-021 Each valid compare with y_in != exp SHALL increment err_cnt by 1; no wrap (max 64 fits 7 bits).
REQ-022 start while busy SHALL be ignored; start in DONE SHALL restart exactly as in IDLE.
REQ-023 Pipeline valid flags SHALL be cleared on sweep start, so no stale compare from a previous sweep.

Reset
REQ-024 rst_n low SHALL immediately force IDLE, vec_out = 0, busy = 0, done = 0, err_cnt = 0, pipeline cleared, regardless of state.
REQ-025 Mid-sweep reset SHALL abort the sweep; first start after release SHALL begin at vec_out = 0.
REQ-026 pass SHALL read 1 during reset (err_cnt = 0) but is ignored because done = 0.

Configuration
REQ-027 Macro LOGIC_TREE_EXERCISER_ERR_LOG_EN SHALL gate a first-failure log.
REQ-028 Defined: extra outputs first_err_valid (1) and first_err_vec (6); first mismatch of a sweep captures its vector and sets first_err_valid; later mismatches ignored; both cleared on reset and sweep start.
REQ-029 Undefined: these ports and registers SHALL be absent; all other behaviour identical.

Verification
REQ-030 RESP_LAT = 1, y_in driven by correct tree delayed 1 cycle -> done after edge k+65, err_cnt = 0, pass = 1.
REQ-031 RESP_LAT = 1, y_in tied 0 -> err_cnt = 19, pass = 0; with ERR_LOG_EN first_err_vec = 6'b000011.
REQ-032 RESP_LAT = 0, y_in tied 1 -> err_cnt = 45, done after edge k+64.
REQ-033 RESP_LAT = 3, correct delayed tree; start pulsed during DRIVE -> ignored; done after edge k+67, err_cnt = 0.
REQ-034 rst_n pulsed low at vec_out = 20 -> all outputs to reset values asynchronously; restart yields full 64-vector sweep, err_cnt = 0.
REQ-035 Back-to-back: start in DONE after a failing sweep (err_cnt = 19) -> err_cnt = 0 at restart edge, second clean sweep ends pass = 1.
